instr_encoder_loader: RTL and testbench

- Encodes instruction requests (opcode, func, register and immediate fields) into 32-bit machine words, using the same opcode/func classes that the processor's control decoder consumes.
- Writes each encoded word into instruction memory, reads it back and checks it.
- Used at bring-up to load programs into instruction memory ahead of the processor core, and as the encoder side for decode-path verification.

---
 rtl/instr_encoder_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction requests into 32-bit words,
// writes each word to instruction memory, reads it back and verifies it.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   clear             return pointer to BASE_ADDR, clear count and flags
//   in_valid/in_ready request handshake
//   opcode, func, rs, rt, shamt, imm   request fields
//   imem_we/imem_re   memory write / read strobes (never together)
//   imem_addr         memory word address (write pointer)
//   imem_wdata        encoded word, held through write and verify
//   imem_rdata        read data, valid the cycle after imem_re
//   word_count        words written and verified
//   full              last address verified, no more requests taken
//   err_range         sticky, immediate did not fit its field
//   err_verify        sticky, readback did not match
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        opcode,
   input  logic [10:0]       func,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        shamt,
   input  logic [25:0]       imm,
   output logic              imem_we,
   output logic              imem_re,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              err_range,
   output logic              err_verify
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      CHECK
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [3:0]  op;
   logic        fmt_r;
   logic        fmt_i;
   logic        fmt_b;
   logic        fmt_j;
   logic [31:0] enc_word;
   logic        in_range;
   logic        accept;
   logic        verify_ok;

   // Format classes follow the low opcode nibble, matching the
   // control decoder's grouping.
   assign op    = opcode[3:0];
   assign fmt_r = (op == 4'd0);
   assign fmt_i = (op == 4'd1) || (op == 4'd2) ||
                  (op == 4'd3) || (op == 4'd4);
   assign fmt_b = (op[3:1] == 3'b011);
   assign fmt_j = (op == 4'd5) || op[3];

   always_comb begin
      enc_word = '0;
      in_range = 1'b1;
      unique case (1'b1)
         fmt_r: begin
            enc_word = {opcode, rs, rt, shamt, func};
         end
         fmt_i: begin
            enc_word = {opcode, rs, rt, imm[15:0]};
            in_range = (imm == {{10{imm[15]}}, imm[15:0]});
         end
         fmt_b: begin
            enc_word = {opcode, rs, imm[20:0]};
            in_range = (imm == {{5{imm[20]}}, imm[20:0]});
         end
         fmt_j: begin
            enc_word = {opcode, imm};
         end
         default: begin
            enc_word = {opcode, imm};
         end
      endcase
   end

   // clear blocks acceptance so a same-cycle request is never lost
   // half-way through the pointer reset.
   assign in_ready  = (state_q == IDLE) && !full && !clear;
   assign accept    = in_valid && in_ready;
   assign imem_we   = (state_q == WRITE);
   assign imem_re   = (state_q == READ);
   assign verify_ok = (imem_rdata == imem_wdata);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept && in_range) begin
               state_d = WRITE;
            end
         end
         WRITE: state_d = READ;
         READ:  state_d = CHECK;
         CHECK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         imem_addr  <= BASE;
         imem_wdata <= '0;
         word_count <= '0;
         full       <= 1'b0;
         err_range  <= 1'b0;
         err_verify <= 1'b0;
      end else if (clear) begin
         // The encoded word is left as is; only the pointer and
         // bookkeeping return to their start values.
         imem_addr  <= BASE;
         word_count <= '0;
         full       <= 1'b0;
         err_range  <= 1'b0;
         err_verify <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  imem_wdata <= enc_word;
                  if (!in_range) begin
                     err_range <= 1'b1;
                  end
               end
            end
            CHECK: begin
               if (verify_ok) begin
                  word_count <= word_count + CNT_ONE;
                  // Last address: flag full and keep the pointer so
                  // it never wraps onto verified words.
                  if (&imem_addr) begin
                     full <= 1'b1;
                  end else begin
                     imem_addr <= imem_addr + ADDR_ONE;
                  end
               end else begin
                  err_verify <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of instr_encoder_loader with a
// write scoreboard and a small instruction memory model.
module tb_instr_encoder_loader;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [10:0] func;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  shamt;
   logic [25:0] imm;
   logic        imem_we;
   logic        imem_re;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic [10:0] word_count;
   logic        full;
   logic        err_range;
   logic        err_verify;

   logic        clear2;
   logic        in_valid2;
   logic        in_ready2;
   logic        we2;
   logic        re2;
   logic [1:0]  addr2;
   logic [31:0] wdata2;
   logic [31:0] rdata2;
   logic [2:0]  count2;
   logic        full2;
   logic        er2;
   logic        ev2;

   logic [31:0] mem  [1024];
   logic [31:0] mem2 [4];
   logic        corrupt;

   logic [9:0]  q_addr [$];
   logic [31:0] q_word [$];

   int total;
   int bad;
   int exp_count;
   int exp_ptr;
   logic exp_rerr;
   logic exp_verr;

   instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .func(func), .rs(rs), .rt(rt),
      .shamt(shamt), .imm(imm),
      .imem_we(imem_we), .imem_re(imem_re),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .imem_rdata(imem_rdata), .word_count(word_count),
      .full(full), .err_range(err_range), .err_verify(err_verify)
   );

   instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear2),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .opcode(opcode), .func(func), .rs(rs), .rt(rt),
      .shamt(shamt), .imm(imm),
      .imem_we(we2), .imem_re(re2),
      .imem_addr(addr2), .imem_wdata(wdata2),
      .imem_rdata(rdata2), .word_count(count2),
      .full(full2), .err_range(er2), .err_verify(ev2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      if (imem_re) imem_rdata <= mem[imem_addr] ^ {31'b0, corrupt};
      if (we2) mem2[addr2] <= wdata2;
      if (re2) rdata2 <= mem2[addr2];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write must match the oldest pending request.
   always @(negedge clk) begin
      if (imem_we) begin
         chk("we_re", {31'b0, imem_re}, 32'd0);
         if (q_word.size() == 0) begin
            chk("wr_unexp", {31'b0, imem_we}, 32'd0);
         end else begin
            chk("wr_addr", {22'b0, imem_addr}, {22'b0, q_addr.pop_front()});
            chk("wr_data", imem_wdata, q_word.pop_front());
         end
      end
   end

   task automatic drive(input logic [5:0] o, input logic [10:0] f,
                        input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] sh, input logic [25:0] im);
      opcode = o;
      func   = f;
      rs     = s;
      rt     = t;
      shamt  = sh;
      imm    = im;
   endtask

   task automatic send(input string tag, input logic [5:0] o,
                       input logic [10:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] sh,
                       input logic [25:0] im, input logic [31:0] w,
                       input bit ok, input bit vok);
      drive(o, f, s, t, sh, im);
      in_valid = 1'b1;
      #1;
      chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
      if (ok) begin
         q_addr.push_back(exp_ptr[9:0]);
         q_word.push_back(w);
      end
      @(negedge clk);
      if (!ok) begin
         in_valid = 1'b0;
         exp_rerr = 1'b1;
         #1;
         chk({tag, "_erng"}, {31'b0, err_range}, 32'd1);
         chk({tag, "_nowe"}, {31'b0, imem_we}, 32'd0);
         chk({tag, "_rdy2"}, {31'b0, in_ready}, 32'd1);
      end else begin
         chk({tag, "_we"}, {31'b0, imem_we}, 32'd1);
         chk({tag, "_wre"}, {31'b0, imem_re}, 32'd0);
         chk({tag, "_wbusy"}, {31'b0, in_ready}, 32'd0);
         chk({tag, "_word"}, imem_wdata, w);
         @(negedge clk);
         chk({tag, "_re"}, {31'b0, imem_re}, 32'd1);
         chk({tag, "_rwe"}, {31'b0, imem_we}, 32'd0);
         chk({tag, "_rbusy"}, {31'b0, in_ready}, 32'd0);
         @(negedge clk);
         chk({tag, "_cbusy"}, {31'b0, in_ready}, 32'd0);
         chk({tag, "_cstb"}, {30'b0, imem_we, imem_re}, 32'd0);
         @(negedge clk);
         in_valid = 1'b0;
         if (vok) begin
            exp_count++;
            exp_ptr++;
         end else begin
            exp_verr = 1'b1;
         end
         #1;
         chk({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
      end
      chk({tag, "_cnt"}, {21'b0, word_count}, exp_count);
      chk({tag, "_addr"}, {22'b0, imem_addr}, exp_ptr);
      chk({tag, "_everr"}, {31'b0, err_verify}, {31'b0, exp_verr});
      chk({tag, "_rerr"}, {31'b0, err_range}, {31'b0, exp_rerr});
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
      chk({tag, "_we"}, {31'b0, imem_we}, 32'd0);
      chk({tag, "_re"}, {31'b0, imem_re}, 32'd0);
      chk({tag, "_addr"}, {22'b0, imem_addr}, 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_cnt"}, {21'b0, word_count}, 32'd0);
      chk({tag, "_full"}, {31'b0, full}, 32'd0);
      chk({tag, "_erng"}, {31'b0, err_range}, 32'd0);
      chk({tag, "_ever"}, {31'b0, err_verify}, 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_count = 0;
      exp_ptr   = 0;
      exp_rerr  = 1'b0;
      exp_verr  = 1'b0;
      corrupt   = 1'b0;
      rst_n     = 1'b0;
      clear     = 1'b0;
      clear2    = 1'b0;
      in_valid  = 1'b0;
      in_valid2 = 1'b0;
      drive(6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0);
      @(negedge clk);
      @(negedge clk);
      reset_checks("rst");
      rst_n = 1'b1;
      @(negedge clk);

      send("addi", 6'd1, 11'd0, 5'd3, 5'd4, 5'd0, 26'h3FFFFFB,
           32'h0464FFFB, 1, 1);
      send("br", 6'd0, 11'h00A, 5'd1, 5'd2, 5'd0, 26'd0,
           32'h0022000A, 1, 1);
      send("bz_oor", 6'd6, 11'd0, 5'd2, 5'd0, 5'd0, 26'h0100000,
           32'd0, 0, 1);
      send("bz_neg", 6'd6, 11'd0, 5'd5, 5'd0, 5'd0, 26'h3FFFFFF,
           32'h18BFFFFF, 1, 1);
      send("lw_max", 6'd3, 11'd0, 5'd0, 5'd1, 5'd0, 26'h0007FFF,
           32'h0C017FFF, 1, 1);
      send("lw_oor", 6'd3, 11'd0, 5'd0, 5'd1, 5'd0, 26'h0008000,
           32'd0, 0, 1);
      send("call", 6'd8, 11'd0, 5'd0, 5'd0, 5'd0, 26'h2ABCDEF,
           32'h22ABCDEF, 1, 1);
      send("b", 6'd5, 11'd0, 5'd0, 5'd0, 5'd0, 26'h0000123,
           32'h14000123, 1, 1);

      corrupt = 1'b1;
      send("bad_rb", 6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd1,
           32'h04000001, 1, 0);
      corrupt = 1'b0;
      send("rewrite", 6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd2,
           32'h04000002, 1, 1);

      // clear in IDLE with a request presented in the same cycle
      drive(6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd9);
      clear    = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("clr_rdy", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      exp_count = 0;
      exp_ptr   = 0;
      exp_rerr  = 1'b0;
      exp_verr  = 1'b0;
      #1;
      chk("clr_cnt", {21'b0, word_count}, 32'd0);
      chk("clr_addr", {22'b0, imem_addr}, 32'd0);
      chk("clr_erng", {31'b0, err_range}, 32'd0);
      chk("clr_ever", {31'b0, err_verify}, 32'd0);
      chk("clr_wdata", imem_wdata, 32'h04000002);
      chk("clr_we", {31'b0, imem_we}, 32'd0);

      send("post_clr", 6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd7,
           32'h04000007, 1, 1);

      // reset while in READ
      drive(6'd3, 11'd0, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);
      q_addr.push_back(exp_ptr[9:0]);
      q_word.push_back(32'h0C22FFFF);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("rd_re", {31'b0, imem_re}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      reset_checks("rst_rd");
      rst_n = 1'b1;
      exp_count = 0;
      exp_ptr   = 0;

      // clear while in WRITE
      drive(6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd7);
      q_addr.push_back(exp_ptr[9:0]);
      q_word.push_back(32'h04000007);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("cw_we", {31'b0, imem_we}, 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      chk("cw_rdy", {31'b0, in_ready}, 32'd1);
      chk("cw_stb", {30'b0, imem_we, imem_re}, 32'd0);
      chk("cw_addr", {22'b0, imem_addr}, 32'd0);
      chk("cw_cnt", {21'b0, word_count}, 32'd0);

      send("recover", 6'd0, 11'h00A, 5'd1, 5'd2, 5'd0, 26'd0,
           32'h0022000A, 1, 1);

      // four-word memory fills after four verified words
      drive(6'd1, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0);
      in_valid2 = 1'b1;
      repeat (12) @(negedge clk);
      chk("f3_cnt", {29'b0, count2}, 32'd3);
      chk("f3_full", {31'b0, full2}, 32'd0);
      repeat (4) @(negedge clk);
      chk("f4_full", {31'b0, full2}, 32'd1);
      chk("f4_rdy", {31'b0, in_ready2}, 32'd0);
      chk("f4_addr", {30'b0, addr2}, 32'd3);
      chk("f4_cnt", {29'b0, count2}, 32'd4);
      repeat (4) @(negedge clk);
      chk("f4_hold", {29'b0, count2}, 32'd4);
      chk("f4_nowe", {31'b0, we2}, 32'd0);
      in_valid2 = 1'b0;
      clear2    = 1'b1;
      @(negedge clk);
      clear2 = 1'b0;
      #1;
      chk("f_clr_full", {31'b0, full2}, 32'd0);
      chk("f_clr_addr", {30'b0, addr2}, 32'd0);
      chk("f_clr_cnt", {29'b0, count2}, 32'd0);
      chk("f_clr_rdy", {31'b0, in_ready2}, 32'd1);

      repeat (2) @(negedge clk);
      chk("sb_empty", q_word.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
